// File: rtl/acia_pkg.sv
// acia_pkg: shared types and helpers for the 6551-style ACIA transmitter
package acia_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} tx_state_e;
  typedef enum logic [1:0] {Wl8, Wl7, Wl6, Wl5} word_len_e;
  typedef enum logic [1:0] {ParOdd, ParEven, ParMark, ParSpace} parity_e;
  function automatic logic [3:0] data_bits(word_len_e wl);
    return 4'd8 - {2'b00, wl};
  endfunction
endpackage

// File: rtl/acia_tx.sv
// acia_tx: double-buffered 6551-style serial transmitter (start, 5-8 data, parity, 1-2 stop)
module acia_tx
  import acia_pkg::*;
#(
  parameter int TICKS_PER_BIT = 1
) (
  input  logic       xtli,
  input  logic       reset_n,
  input  logic       tx_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  input  logic [1:0] word_len,
  input  logic       stop2,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       brk,
  input  logic       cts_n,
  output logic       txd,
  output logic       tdre,
  output logic       tx_busy
);
  localparam int PW = TICKS_PER_BIT > 1 ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_BIT - 1);
  tx_state_e state, state_d;
  logic tx_clk_q, tx_edge, tick, xfer, frame_end, last_stop;
  logic [PW-1:0] pre;
  logic [7:0] tdr, sh, sh_d, masked;
  logic [2:0] cnt, cnt_d;
  logic [3:0] nbits;
  logic par_en_q, par_q, par_new, two_stop_q, two_stop_d, txd_d;
  parity_e pm;
  assign tx_edge = tx_clk & ~tx_clk_q;
  assign tick = tx_edge & (pre == PRE_MAX);
  assign tx_busy = state != IDLE;
  assign masked = tdr & (8'hFF >> word_len);
  assign pm = parity_e'(parity_mode);
  assign par_new = pm == ParMark ? 1'b1 : pm == ParSpace ? 1'b0 : pm == ParEven ? ^masked : ~^masked;
  assign last_stop = state == STOP2 || (state == STOP1 && !two_stop_q);
  assign frame_end = state == IDLE || last_stop;
  always_comb begin
    state_d = state;
    sh_d = sh;
    cnt_d = cnt;
    xfer = 1'b0;
    two_stop_d = two_stop_q;
    if (tick) begin
      if (frame_end && brk) begin
        state_d = BREAK;
        two_stop_d = 1'b0;
      end else if (frame_end && !tdre && !cts_n) begin
        state_d = START;
        sh_d = tdr;
        xfer = 1'b1;
        two_stop_d = stop2 & ~(word_len_e'(word_len) == Wl8 & parity_en);
      end else if (last_stop) begin
        state_d = IDLE;
      end else begin
        case (state)
          START: begin
            state_d = DATA;
            cnt_d = '0;
          end
          DATA:
            if ({1'b0, cnt} == nbits - 4'd1) state_d = par_en_q ? PARITY : STOP1;
            else begin
              sh_d = sh >> 1;
              cnt_d = cnt + 3'd1;
            end
          PARITY: state_d = STOP1;
          STOP1: state_d = STOP2;
          BREAK: state_d = brk ? BREAK : STOP1;
          default: state_d = state;
        endcase
      end
    end
    txd_d = state_d == DATA ? sh_d[0] : state_d == PARITY ? par_q :
            !(state_d == START || state_d == BREAK);
  end
  always_ff @(posedge xtli or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      tx_clk_q <= 1'b0;
      pre <= '0;
      tdr <= '0;
      sh <= '0;
      cnt <= '0;
      nbits <= '0;
      par_en_q <= 1'b0;
      par_q <= 1'b0;
      two_stop_q <= 1'b0;
      txd <= 1'b1;
      tdre <= 1'b1;
    end else begin
      tx_clk_q <= tx_clk;
      if (tx_edge) pre <= pre == PRE_MAX ? '0 : pre + 1'b1;
      state <= state_d;
      sh <= sh_d;
      cnt <= cnt_d;
      txd <= txd_d;
      two_stop_q <= two_stop_d;
      // a load coinciding with a transfer wins: shifter took the old TDR, new data stays pending
      if (tx_load) begin
        tdr <= tx_data;
        tdre <= 1'b0;
      end else if (xfer) tdre <= 1'b1;
      if (xfer) begin
        nbits <= data_bits(word_len_e'(word_len));
        par_en_q <= parity_en;
        par_q <= par_new;
      end
    end
endmodule

// File: tb/tb_acia_tx.sv
// tb_acia_tx: randomized scoreboard bench for acia_tx with a frame-level reference model
module tb_acia_tx;
  logic xtli = 1'b0, reset_n = 1'b0, tx_clk = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_load = 1'b0;
  logic [1:0] word_len = '0, parity_mode = '0;
  logic stop2 = 1'b0, parity_en = 1'b0, brk = 1'b0, cts_n = 1'b0;
  logic txd, tdre, tx_busy;
  int total = 0, bad = 0;
  bit mon_off = 1'b0;
  int div = 0;
  typedef struct {logic [15:0] bits; int len; bit is_brk; bit b2b;} item_t;
  item_t sb[$];

  acia_tx #(.TICKS_PER_BIT(1)) dut (
    .xtli(xtli), .reset_n(reset_n), .tx_clk(tx_clk), .tx_data(tx_data), .tx_load(tx_load),
    .word_len(word_len), .stop2(stop2), .parity_en(parity_en), .parity_mode(parity_mode),
    .brk(brk), .cts_n(cts_n), .txd(txd), .tdre(tdre), .tx_busy(tx_busy)
  );

  always #5 xtli = ~xtli;
  // baud clock toggles every 2 xtli cycles: one bit = 4 xtli cycles
  always @(posedge xtli) begin
    if (div == 1) begin
      div <= 0;
      tx_clk <= ~tx_clk;
    end else div <= div + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    return which == 0 ? tdre : which == 1 ? txd : tx_busy;
  endfunction

  task automatic wait_for(input int which, input logic val, input int max, input string name, output int n);
    n = 0;
    while (sig(which) !== val && n < max) begin
      @(negedge xtli);
      n++;
    end
    if (sig(which) !== val) check({name, "_timeout"}, 32'(sig(which)), 32'(val));
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge xtli);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge xtli);
    tx_load = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] wl, input logic s2, input logic pe, input logic [1:0] pm);
    word_len = wl;
    stop2 = s2;
    parity_en = pe;
    parity_mode = pm;
  endtask

  task automatic push(input logic [7:0] d, input bit b2b);
    item_t it;
    int n, ones, k, stops;
    n = 8 - int'(word_len);
    it.bits = '0;
    k = 1;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      it.bits[k] = d[i];
      ones += int'(d[i]);
      k++;
    end
    if (parity_en) begin
      it.bits[k] = parity_mode == 2'd0 ? (ones % 2 == 0) : parity_mode == 2'd1 ? (ones % 2 == 1) :
                   parity_mode == 2'd2;
      k++;
    end
    stops = (stop2 && !(n == 8 && parity_en)) ? 2 : 1;
    for (int i = 0; i < stops; i++) begin
      it.bits[k] = 1'b1;
      k++;
    end
    it.len = k;
    it.is_brk = 1'b0;
    it.b2b = b2b;
    sb.push_back(it);
  endtask

  task automatic push_brk();
    item_t it;
    it.bits = '0;
    it.len = 0;
    it.is_brk = 1'b1;
    it.b2b = 1'b0;
    sb.push_back(it);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_busy !== 1'b0 || sb.size() != 0) && n < 5000) begin
      @(negedge xtli);
      n++;
    end
    check("idle_timeout", 32'(n < 5000), 32'd1);
    repeat (8) @(negedge xtli);
  endtask

  initial begin : monitor
    item_t it;
    logic [15:0] got;
    int gap, n;
    gap = 100;
    forever begin
      @(negedge xtli);
      if (txd === 1'b0 && !mon_off && reset_n === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
          n = 0;
          while (txd === 1'b0 && n < 4000) begin
            @(negedge xtli);
            n++;
          end
        end else begin
          it = sb.pop_front();
          if (it.b2b) check("back_to_back_gap", 32'(gap < 4), 32'd1);
          if (it.is_brk) begin
            n = 0;
            while (txd === 1'b0 && n < 4000) begin
              @(negedge xtli);
              n++;
            end
            check("break_length", 32'(n >= 8 && n < 4000), 32'd1);
            repeat (2) @(negedge xtli);
            check("break_stop_bit", 32'(txd), 32'd1);
            repeat (4) @(negedge xtli);
            check("break_then_idle", 32'(tx_busy), 32'd0);
          end else begin
            got = '0;
            repeat (2) @(negedge xtli);
            for (int i = 0; i < it.len; i++) begin
              got[i] = txd;
              if (i < it.len - 1) repeat (4) @(negedge xtli);
            end
            check("frame", 32'(got), 32'(it.bits));
          end
        end
        gap = 0;
      end else gap++;
    end
  end

  initial begin : stim
    int n, lows;
    logic [7:0] d;
    repeat (3) @(negedge xtli);
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_tdre", 32'(tdre), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge xtli);
    // 8N1 0x55
    cfg(2'd0, 1'b0, 1'b0, 2'd0);
    push(8'h55, 1'b0);
    load(8'h55);
    check("tdre_after_load", 32'(tdre), 32'd0);
    wait_for(1, 1'b0, 20, "start_8n1", n);
    check("tdre_at_start", 32'(tdre), 32'd1);
    wait_idle();
    check("busy_after_8n1", 32'(tx_busy), 32'd0);
    // 7E1 and 7O1 0x41
    cfg(2'd1, 1'b0, 1'b1, 2'd1);
    push(8'h41, 1'b0);
    load(8'h41);
    wait_idle();
    cfg(2'd1, 1'b0, 1'b1, 2'd0);
    push(8'h41, 1'b0);
    load(8'h41);
    wait_idle();
    // 8N2 back to back
    cfg(2'd0, 1'b1, 1'b0, 2'd0);
    push(8'hA5, 1'b0);
    load(8'hA5);
    wait_for(0, 1'b1, 20, "xfer_a5", n);
    repeat (8) @(negedge xtli);
    push(8'h3C, 1'b1);
    load(8'h3C);
    wait_for(0, 1'b1, 100, "xfer_3c", n);
    check("second_start_txd", 32'(txd), 32'd0);
    wait_idle();
    // cts_n holds off a pending frame
    cfg(2'd0, 1'b0, 1'b0, 2'd0);
    cts_n = 1'b1;
    load(8'h96);
    repeat (20) @(negedge xtli);
    check("cts_txd", 32'(txd), 32'd1);
    check("cts_tdre", 32'(tdre), 32'd0);
    check("cts_busy", 32'(tx_busy), 32'd0);
    push(8'h96, 1'b0);
    cts_n = 1'b0;
    wait_for(1, 1'b0, 10, "cts_start", n);
    check("cts_start_latency", 32'(n <= 5), 32'd1);
    wait_idle();
    // break requested mid-frame
    push(8'hC3, 1'b0);
    push_brk();
    load(8'hC3);
    wait_for(2, 1'b1, 20, "brk_busy", n);
    brk = 1'b1;
    repeat (80) @(negedge xtli);
    brk = 1'b0;
    wait_idle();
    // randomized frames, config changed while the previous frame shifts
    for (int k = 0; k < 30; k++) begin
      cfg(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
      d = 8'($urandom);
      push(d, 1'b0);
      load(d);
      wait_for(0, 1'b1, 200, "rand_xfer", n);
      repeat ($urandom_range(0, 30)) @(negedge xtli);
    end
    wait_idle();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    // reset mid-data drops the frame
    mon_off = 1'b1;
    cfg(2'd0, 1'b0, 1'b0, 2'd0);
    load(8'h00);
    wait_for(1, 1'b0, 20, "rst_start", n);
    repeat (10) @(negedge xtli);
    reset_n = 1'b0;
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tdre", 32'(tdre), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge xtli);
    reset_n = 1'b1;
    lows = 0;
    repeat (80) begin
      @(negedge xtli);
      if (txd !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("no_residual_frame", 32'(lows), 32'd0);
    check("post_rst_tdre", 32'(tdre), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
